// File: rtl/crc_bus_pkg.sv
// Shared definitions for the CRC bus master: slave register map, control
// encodings and the master FSM state set.
package crc_bus_pkg;

  localparam logic [1:0] CRC_ADDR_DATA = 2'd0;
  localparam logic [1:0] CRC_ADDR_CTRL = 2'd1;
  localparam logic [1:0] CRC_ADDR_STAT = 2'd2;

  localparam int CRC_CTRL_RUN  = 1;
  localparam int CRC_CTRL_STOP = 0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_CLR,
    S_WR_DATA,
    S_WR_SET,
    S_POLL_RD,
    S_POLL_WT,
    S_GAP,
    S_RES_RD,
    S_RES_WT,
    S_ABORT
  } crc_state_e;

endpackage

// File: rtl/crc_poll_timer.sv
// Poll attempt counter and inter-poll gap counter for the CRC bus master.
module crc_poll_timer #(
  parameter int MAX_POLLS = 255,
  parameter int POLL_GAP  = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic poll_clr,
  input  logic poll_inc,
  input  logic gap_run,
  output logic gap_done,
  output logic poll_exhausted
);

  localparam int PW = $clog2(MAX_POLLS + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [PW-1:0] POLL_MAX  = PW'(MAX_POLLS);
  localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

  logic [PW-1:0] poll_cnt;
  logic [GW-1:0] gap_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (poll_clr)
        poll_cnt <= '0;
      else if (poll_inc && poll_cnt != POLL_MAX)
        poll_cnt <= poll_cnt + 1'b1;
      if (gap_run && !gap_done)
        gap_cnt <= gap_cnt + 1'b1;
      else
        gap_cnt <= '0;
    end
  end

  assign gap_done = (POLL_GAP == 0) || (gap_cnt == GAP_LAST);
  // Look-ahead: true when the failed poll being decided now uses up the budget.
  assign poll_exhausted = (poll_cnt == POLL_LAST);

endmodule

// File: rtl/crc_bus_master.sv
// Bus initiator for the memory-mapped CRC slave: write word, kick, poll done,
// read result back and return it with a one-cycle valid pulse.
module crc_bus_master
  import crc_bus_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CRC_WIDTH  = 3,
  parameter int MAX_POLLS  = 255,
  parameter int POLL_GAP   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  result_valid,
  output logic [CRC_WIDTH-1:0]  result,
  output logic                  timeout_err,
  output logic                  cs,
  output logic                  write,
  output logic                  read,
  output logic [1:0]            addr,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data
);

  crc_state_e            state, state_nxt;
  logic [DATA_WIDTH-1:0] latched_word;
  logic                  cs_d, wr_d, rd_d;
  logic [1:0]            addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  gap_done, poll_exhausted;
  logic                  rd_unused;

  assign rd_unused = ^read_data;

  crc_poll_timer #(.MAX_POLLS(MAX_POLLS), .POLL_GAP(POLL_GAP)) u_timer (
    .clk            (clk),
    .reset_n        (reset_n),
    .poll_clr       (state == S_WR_SET),
    .poll_inc       ((state == S_POLL_WT) && !read_data[0]),
    .gap_run        (state == S_GAP),
    .gap_done       (gap_done),
    .poll_exhausted (poll_exhausted)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start && !result_valid && !timeout_err) state_nxt = S_WR_CLR;
      S_WR_CLR:  state_nxt = S_WR_DATA;
      S_WR_DATA: state_nxt = S_WR_SET;
      S_WR_SET:  state_nxt = S_POLL_RD;
      S_POLL_RD: state_nxt = S_POLL_WT;
      S_POLL_WT: begin
        if (read_data[0])        state_nxt = S_RES_RD;
        else if (poll_exhausted) state_nxt = S_ABORT;
        else if (POLL_GAP == 0)  state_nxt = S_POLL_RD;
        else                     state_nxt = S_GAP;
      end
      S_GAP:     if (gap_done) state_nxt = S_POLL_RD;
      S_RES_RD:  state_nxt = S_RES_WT;
      S_RES_WT:  state_nxt = S_IDLE;
      S_ABORT:   state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the state being entered so the registered
  // strobe lines up with the state that owns the access.
  always_comb begin
    cs_d    = 1'b0;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = addr;
    wdata_d = write_data;
    case (state_nxt)
      S_WR_CLR, S_ABORT: begin
        cs_d = 1'b1; wr_d = 1'b1; addr_d = CRC_ADDR_CTRL;
        wdata_d = DATA_WIDTH'(CRC_CTRL_STOP);
      end
      S_WR_DATA: begin
        cs_d = 1'b1; wr_d = 1'b1; addr_d = CRC_ADDR_DATA;
        wdata_d = latched_word;
      end
      S_WR_SET: begin
        cs_d = 1'b1; wr_d = 1'b1; addr_d = CRC_ADDR_CTRL;
        wdata_d = DATA_WIDTH'(CRC_CTRL_RUN);
      end
      S_POLL_RD: begin cs_d = 1'b1; rd_d = 1'b1; addr_d = CRC_ADDR_STAT; end
      S_RES_RD:  begin cs_d = 1'b1; rd_d = 1'b1; addr_d = CRC_ADDR_CTRL; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs           <= 1'b0;
      write        <= 1'b0;
      read         <= 1'b0;
      addr         <= '0;
      write_data   <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      result       <= '0;
      latched_word <= '0;
    end else begin
      cs           <= cs_d;
      write        <= wr_d;
      read         <= rd_d;
      addr         <= addr_d;
      write_data   <= wdata_d;
      busy         <= (state_nxt != S_IDLE);
      result_valid <= (state == S_RES_WT);
      timeout_err  <= (state == S_ABORT);
      if (state == S_RES_WT) result <= read_data[CRC_WIDTH-1:0];
      if (state == S_IDLE && state_nxt == S_WR_CLR) latched_word <= data_in;
    end
  end

endmodule

// File: tb/tb_crc_bus_master.sv
// Randomized scoreboard bench for crc_bus_master with a behavioural CRC slave.
module tb_crc_bus_master;

  localparam int DW = 32;
  localparam int CW = 3;
  localparam int MP = 4;
  localparam int G  = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] read_data = '0;
  logic          busy, result_valid, timeout_err, cs, write, read;
  logic [CW-1:0] result;
  logic [1:0]    addr;
  logic [DW-1:0] write_data;

  always #5 clk = ~clk;

  crc_bus_master #(.DATA_WIDTH(DW), .CRC_WIDTH(CW), .MAX_POLLS(MP), .POLL_GAP(G)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .data_in      (data_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result),
    .timeout_err  (timeout_err),
    .cs           (cs),
    .write        (write),
    .read         (read),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  typedef struct {bit wr; logic [1:0] addr; logic [DW-1:0] data; int cyc;} bus_t;
  typedef struct {bit tmo; logic [CW-1:0] res; int cyc; int busy_cycles;} done_t;
  typedef struct {int polls; logic [DW-1:0] res;} cfg_t;

  bus_t  exp_bus[$];
  done_t exp_done[$];
  cfg_t  slave_cfg[$];

  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            free_edge = 0;
  int            busy_cnt = 0;
  logic [CW-1:0] model_result = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: done appears on the configured poll number (0 = never); upper
  // read_data bits carry noise so only the defined bits should matter.
  int            s_polls = 0;
  int            s_seen = 0;
  logic [DW-1:0] s_res = '0;

  always @(posedge clk) begin
    read_data <= DW'($urandom);
    if (cs && write && addr == 2'd1 && write_data == 1) begin
      if (slave_cfg.size() > 0) begin
        s_polls <= slave_cfg[0].polls;
        s_res   <= slave_cfg[0].res;
        void'(slave_cfg.pop_front());
      end
      s_seen <= 0;
    end
    if (cs && read && addr == 2'd2) begin
      s_seen    <= s_seen + 1;
      read_data <= (DW'($urandom) & ~DW'(1)) | DW'(s_polls != 0 && s_seen + 1 >= s_polls);
    end
    if (cs && read && addr == 2'd1) read_data <= s_res;
  end

  // Reference: 3 setup writes, each poll is read + wait, failed polls add a
  // gap, success adds result read + wait, timeout adds one abort write.
  function automatic void expect_txn(input int t0, input logic [DW-1:0] d,
                                     input int polls, input logic [DW-1:0] rw);
    int n, last;
    n = (polls == 0) ? MP : polls;
    last = t0 + 3 + (n - 1) * (2 + G);
    slave_cfg.push_back('{polls, rw});
    exp_bus.push_back('{1'b1, 2'd1, DW'(0), t0});
    exp_bus.push_back('{1'b1, 2'd0, d, t0 + 1});
    exp_bus.push_back('{1'b1, 2'd1, DW'(1), t0 + 2});
    for (int j = 0; j < n; j++) exp_bus.push_back('{1'b0, 2'd2, DW'(0), t0 + 3 + j * (2 + G)});
    if (polls != 0) begin
      exp_bus.push_back('{1'b0, 2'd1, DW'(0), last + 2});
      model_result = CW'(rw % (DW'(1) << CW));
      exp_done.push_back('{1'b0, model_result, last + 4, last + 4 - t0});
      free_edge = last + 6;
    end else begin
      exp_bus.push_back('{1'b1, 2'd1, DW'(0), last + 2});
      exp_done.push_back('{1'b1, model_result, last + 3, last + 3 - t0});
      free_edge = last + 5;
    end
  endfunction

  // Monitor: every bus access and every completion pulse is matched
  // against the head of its queue.
  initial begin
    bus_t  eb;
    done_t ed;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy_cnt = 0;
      end else begin
        if (cs || read || write) begin
          checks++;
          if (exp_bus.size() == 0) begin
            errors++;
            $display("FAIL bus_access: got cs=%0b rd=%0b wr=%0b addr=%0d data=%h cyc=%0d, expected no access",
                     cs, read, write, addr, write_data, cyc);
          end else begin
            eb = exp_bus.pop_front();
            if (!cs || read == write || write != eb.wr || addr != eb.addr ||
                (eb.wr && write_data != eb.data) || cyc != eb.cyc) begin
              errors++;
              $display("FAIL bus_access: got cs=%0b rd=%0b wr=%0b addr=%0d data=%h cyc=%0d, expected wr=%0b addr=%0d data=%h cyc=%0d",
                       cs, read, write, addr, write_data, cyc, eb.wr, eb.addr, eb.data, eb.cyc);
            end
          end
        end
        if (busy) busy_cnt++;
        if (result_valid || timeout_err) begin
          checks++;
          if (exp_done.size() == 0) begin
            errors++;
            $display("FAIL completion: got rv=%0b to=%0b res=%0h cyc=%0d, expected no completion",
                     result_valid, timeout_err, result, cyc);
          end else begin
            ed = exp_done.pop_front();
            if (result_valid != !ed.tmo || timeout_err != ed.tmo || result != ed.res ||
                cyc != ed.cyc || busy || busy_cnt != ed.busy_cycles) begin
              errors++;
              $display("FAIL completion: got rv=%0b to=%0b res=%0h cyc=%0d busy=%0b busy_cycles=%0d, expected to=%0b res=%0h cyc=%0d busy=0 busy_cycles=%0d",
                       result_valid, timeout_err, result, cyc, busy, busy_cnt,
                       ed.tmo, ed.res, ed.cyc, ed.busy_cycles);
            end
          end
          busy_cnt = 0;
        end
      end
    end
  end

  // Called at a negedge; holds start for 'hold' edges and records every
  // edge on which the master should accept it.
  task automatic issue(input logic [DW-1:0] d, input int polls,
                       input logic [DW-1:0] rw, input int hold, output int t0);
    t0 = -1;
    start = 1'b1;
    data_in = d;
    for (int h = 0; h < hold; h++) begin
      if (cyc + 1 >= free_edge) begin
        t0 = cyc + 1;
        expect_txn(t0, d, polls, rw);
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((exp_bus.size() != 0 || exp_done.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL wait_idle: got %0d accesses and %0d completions pending after %0d cycles, expected 0",
               exp_bus.size(), exp_done.size(), budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (cs || read || write || busy || result_valid || timeout_err || result != model_result) begin
      errors++;
      $display("FAIL %s: got cs=%0b rd=%0b wr=%0b busy=%0b rv=%0b to=%0b res=%0h, expected all 0 and res=%0h",
               name, cs, read, write, busy, result_valid, timeout_err, result, model_result);
    end
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge clk);
    check_quiet("reset_state");
    checks++;
    if (addr != 2'd0 || write_data != '0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%0d wdata=%h, expected 0 and 0", addr, write_data);
    end
    reset_n = 1'b1;
    @(negedge clk);

    issue(32'hDEADBEEF, 1, 32'h0000_0005, 1, t0);
    wait_idle(200);
    issue($urandom, 4, $urandom, 1, t0);
    wait_idle(200);
    issue($urandom, 0, 32'h0, 1, t0);
    wait_idle(200);
    issue($urandom, 2, 32'hFFFF_FFFA, 1, t0);
    wait_idle(200);
    // start still high on the pulse cycle must not launch another run
    issue($urandom, 1, $urandom, 9, t0);
    wait_idle(200);
    issue($urandom, 4, $urandom, 20, t0);
    wait_idle(200);

    // Reset while waiting out the poll gap.
    issue($urandom, 0, 32'h0, 1, t0);
    while (cyc < t0 + 5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_result = '0;
    check_quiet("reset_in_gap");
    exp_bus.delete();
    exp_done.delete();
    slave_cfg.delete();
    free_edge = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    issue($urandom, 1, $urandom, 1, t0);
    wait_idle(200);

    for (int i = 0; i < 12; i++) begin
      issue($urandom, $urandom_range(0, MP), $urandom, $urandom_range(1, 25), t0);
      wait_idle(400);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
